hazard_forward_ctrl: RTL and testbench

// Central hazard/forwarding controller for the 5-stage MIPS32 pipeline. Shadows the

---
 rtl/hazard_forward_ctrl_pkg.sv | 41 ++++
 rtl/hazard_forward_ctrl_if.sv | 44 ++++
 rtl/hazard_forward_ctrl_stage_reg.sv | 41 ++++
 rtl/hazard_forward_ctrl.sv | 160 ++++++++++++++++
 tb/tb_hazard_forward_ctrl.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_forward_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared types and codes for the pipeline hazard/forwarding
//               controller: forward-select codes, FSM states, stage shadow
//               record and the producer-match helper.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

  localparam int REG_AW = 5;

  // Operand source selects for the EX-stage operand muxes
  localparam logic [1:0] FWD_ORIG = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b01;
  localparam logic [1:0] FWD_WB   = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MD_WAIT    = 2'd2
  } hz_state_e;

  // Destination/usage info shadowed alongside one pipeline stage
  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] wr;
  } stage_info_t;

  // True when stage s will write register r; $0 is hard-wired and never produced
  function automatic logic producer_hit(stage_info_t s, logic [REG_AW-1:0] r);
    return s.reg_write && (s.wr != '0) && (s.wr == r);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_forward_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_forward_ctrl_if
// Description : ID-stage decode info in, pipeline control selects out.
//               master = pipeline side, slave = hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_forward_ctrl_if;
  import hazard_pkg::*;

  logic [REG_AW-1:0] Rs_ID;
  logic [REG_AW-1:0] Rt_ID;
  logic              Use_Rs_ID;
  logic              Use_Rt_ID;
  logic [REG_AW-1:0] Write_Reg_ID;
  logic              RegWrite_ID;
  logic              MemRead_ID;
  logic              MemWrite_ID;
  logic              MD_Read_ID;
  logic              MD_Busy;
  logic              Branch_Taken_EX;
  logic [1:0]        Forward_A_EX;
  logic [1:0]        Forward_B_EX;
  logic              Forward_MEM;
  logic              Stall_IF_ID;
  logic              Bubble_ID_EX;
  logic              Flush_IF_ID;

  modport master (
    output Rs_ID, Rt_ID, Use_Rs_ID, Use_Rt_ID, Write_Reg_ID, RegWrite_ID,
           MemRead_ID, MemWrite_ID, MD_Read_ID, MD_Busy, Branch_Taken_EX,
    input  Forward_A_EX, Forward_B_EX, Forward_MEM, Stall_IF_ID,
           Bubble_ID_EX, Flush_IF_ID
  );

  modport slave (
    input  Rs_ID, Rt_ID, Use_Rs_ID, Use_Rt_ID, Write_Reg_ID, RegWrite_ID,
           MemRead_ID, MemWrite_ID, MD_Read_ID, MD_Busy, Branch_Taken_EX,
    output Forward_A_EX, Forward_B_EX, Forward_MEM, Stall_IF_ID,
           Bubble_ID_EX, Flush_IF_ID
  );

endinterface
`default_nettype wire

// File: rtl/hazard_forward_ctrl_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : hz_stage_reg
// Description : One shadow-register stage. Advances every cycle; a bubble
//               loads an all-zero record, reset clears the stage.
// Revision    : 1.0 - initial release
// ============================================================================
module hz_stage_reg
  import hazard_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        bubble_i,
  input  stage_info_t d_i,
  output stage_info_t q_o
);

  stage_info_t stage_q;
  stage_info_t stage_d;

  // Bubble replaces the incoming record with a NOP that writes nothing
  always_comb begin
    stage_d = d_i;
    if (bubble_i) begin
      stage_d = '0;
    end
  end

  // Stage never freezes: it always takes the upstream record
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q_o = stage_q;

endmodule
`default_nettype wire

// File: rtl/hazard_forward_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_forward_ctrl
// Description : Hazard/forwarding controller for the 5-stage MIPS32 pipeline.
//               Shadows EX/MEM/WB destination info, decodes EX operand and
//               MEM store-data forwarding, and issues stall/bubble/flush.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_forward_ctrl
  import hazard_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  hazard_forward_ctrl_if.slave bus
);

  stage_info_t id_info;
  stage_info_t ex_q;
  stage_info_t mem_q;
  stage_info_t wb_q;

  hz_state_e   state_q;
  hz_state_e   state_d;

  logic        hz_ld;
  logic        hz_md;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic        fwd_mem;
  logic        stall;
  logic        bubble;
  logic        flush;

  // Pack the ID-stage decode into the record that enters EX
  always_comb begin
    id_info           = '0;
    id_info.valid     = 1'b1;
    id_info.reg_write = bus.RegWrite_ID;
    id_info.mem_read  = bus.MemRead_ID;
    id_info.mem_write = bus.MemWrite_ID;
    id_info.rs        = bus.Rs_ID;
    id_info.rt        = bus.Rt_ID;
    id_info.wr        = bus.Write_Reg_ID;
  end

  hz_stage_reg u_ex (
    .clk      (clk),
    .reset    (reset),
    .bubble_i (bubble),
    .d_i      (id_info),
    .q_o      (ex_q)
  );

  hz_stage_reg u_mem (
    .clk      (clk),
    .reset    (reset),
    .bubble_i (1'b0),
    .d_i      (ex_q),
    .q_o      (mem_q)
  );

  hz_stage_reg u_wb (
    .clk      (clk),
    .reset    (reset),
    .bubble_i (1'b0),
    .d_i      (mem_q),
    .q_o      (wb_q)
  );

  // Hazard detection against the ID instruction; a store's rt is data only
  // and is picked up later by the MEM store-data forward, so it never stalls
  always_comb begin
    hz_ld = ex_q.mem_read && (ex_q.wr != '0) &&
            ((bus.Use_Rs_ID && (bus.Rs_ID == ex_q.wr)) ||
             (bus.Use_Rt_ID && !bus.MemWrite_ID && (bus.Rt_ID == ex_q.wr)));
    hz_md = bus.MD_Read_ID && bus.MD_Busy;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and all control outputs; reset forces every output low
  always_comb begin
    state_d = state_q;
    fwd_a   = FWD_ORIG;
    fwd_b   = FWD_ORIG;
    fwd_mem = 1'b0;
    stall   = 1'b0;
    bubble  = 1'b0;
    flush   = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (hz_ld) begin
          state_d = ST_LOAD_STALL;
        end else if (hz_md) begin
          state_d = ST_MD_WAIT;
        end
      end
      ST_LOAD_STALL: state_d = ST_RUN;
      ST_MD_WAIT: begin
        if (!bus.MD_Busy) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase

    // A taken branch kills the ID instruction, so any pending stall is moot
    if (bus.Branch_Taken_EX) begin
      state_d = ST_RUN;
    end

    if (!reset) begin
      // The younger producer (MEM) holds the newer value, so it wins over WB
      if (producer_hit(mem_q, ex_q.rs)) begin
        fwd_a = FWD_MEM;
      end else if (producer_hit(wb_q, ex_q.rs)) begin
        fwd_a = FWD_WB;
      end
      if (producer_hit(mem_q, ex_q.rt)) begin
        fwd_b = FWD_MEM;
      end else if (producer_hit(wb_q, ex_q.rt)) begin
        fwd_b = FWD_WB;
      end

      fwd_mem = mem_q.mem_write && producer_hit(wb_q, mem_q.rt);

      if (bus.Branch_Taken_EX) begin
        flush  = 1'b1;
        bubble = 1'b1;
      end else if (hz_ld || hz_md) begin
        stall  = 1'b1;
        bubble = 1'b1;
      end
    end
  end

  assign bus.Forward_A_EX = fwd_a;
  assign bus.Forward_B_EX = fwd_b;
  assign bus.Forward_MEM  = fwd_mem;
  assign bus.Stall_IF_ID  = stall;
  assign bus.Bubble_ID_EX = bubble;
  assign bus.Flush_IF_ID  = flush;

  // Shadow fields carried for completeness but not consumed by any decode
  logic unused_fields;
  assign unused_fields = ^{ex_q.valid, ex_q.reg_write, ex_q.mem_write,
                           mem_q.valid, mem_q.mem_read, mem_q.rs,
                           wb_q.valid, wb_q.mem_read, wb_q.mem_write,
                           wb_q.rs, wb_q.rt};

endmodule
`default_nettype wire

// File: tb/tb_hazard_forward_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_forward_ctrl
// Description : Self-checking bench for hazard_forward_ctrl: an in-flight
//               instruction model compared every cycle, plus directed
//               scenarios with literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_forward_ctrl;
  import hazard_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_forward_ctrl_if bus ();

  hazard_forward_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit rw;
    bit mr;
    bit mw;
    int rs;
    int rt;
    int wr;
  } instr_t;

  instr_t    pipe [1:3];   // 1 = EX, 2 = MEM, 3 = WB
  hz_state_e m_state;

  initial begin
    for (int i = 1; i <= 3; i++) pipe[i] = '{default: 0};
    m_state = ST_RUN;
  end

  // Source register value comes from the nearest older writer still in flight
  function automatic logic [1:0] m_fwd(int src);
    for (int s = 2; s <= 3; s++) begin
      if (pipe[s].rw && pipe[s].wr != 0 && pipe[s].wr == src)
        return (s == 2) ? FWD_MEM : FWD_WB;
    end
    return FWD_ORIG;
  endfunction

  function automatic bit m_load_use();
    if (!pipe[1].mr || pipe[1].wr == 0) return 1'b0;
    return (bus.Use_Rs_ID && int'(bus.Rs_ID) == pipe[1].wr) ||
           (bus.Use_Rt_ID && !bus.MemWrite_ID && int'(bus.Rt_ID) == pipe[1].wr);
  endfunction

  function automatic bit m_stall_req();
    return m_load_use() || (bus.MD_Read_ID && bus.MD_Busy);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i <= 3; i++) pipe[i] = '{default: 0};
      m_state = ST_RUN;
    end else begin
      bit        lu;
      bit        md;
      hz_state_e nxt;
      lu  = m_load_use();
      md  = bus.MD_Read_ID && bus.MD_Busy;
      nxt = m_state;
      if (m_state == ST_RUN)             nxt = lu ? ST_LOAD_STALL : (md ? ST_MD_WAIT : ST_RUN);
      else if (m_state == ST_LOAD_STALL) nxt = ST_RUN;
      else if (!bus.MD_Busy)             nxt = ST_RUN;
      if (bus.Branch_Taken_EX)           nxt = ST_RUN;
      pipe[3] = pipe[2];
      pipe[2] = pipe[1];
      if (bus.Branch_Taken_EX || lu || md) pipe[1] = '{default: 0};
      else pipe[1] = '{rw: bus.RegWrite_ID, mr: bus.MemRead_ID, mw: bus.MemWrite_ID,
                       rs: int'(bus.Rs_ID), rt: int'(bus.Rt_ID), wr: int'(bus.Write_Reg_ID)};
      m_state = nxt;
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    bit br;
    bit sr;
    bit fm;
    br = !reset && bus.Branch_Taken_EX;
    sr = !reset && m_stall_req();
    fm = !reset && pipe[2].mw && pipe[3].rw && pipe[3].wr != 0 && pipe[3].wr == pipe[2].rt;
    check("m_fwdA",   32'(bus.Forward_A_EX), reset ? 32'd0 : 32'(m_fwd(pipe[1].rs)));
    check("m_fwdB",   32'(bus.Forward_B_EX), reset ? 32'd0 : 32'(m_fwd(pipe[1].rt)));
    check("m_fwdMEM", 32'(bus.Forward_MEM),  32'(fm));
    check("m_flush",  32'(bus.Flush_IF_ID),  32'(br));
    check("m_stall",  32'(bus.Stall_IF_ID),  32'(sr && !br));
    check("m_bubble", 32'(bus.Bubble_ID_EX), 32'(br || sr));
    check("m_state",  32'(dut.state_q),      32'(m_state));
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_id(input int rs, input int rt, input int wr, input bit urs,
                        input bit urt, input bit rw, input bit mr, input bit mw, input bit md);
    bus.Rs_ID        = rs[4:0];
    bus.Rt_ID        = rt[4:0];
    bus.Write_Reg_ID = wr[4:0];
    bus.Use_Rs_ID    = urs;
    bus.Use_Rt_ID    = urt;
    bus.RegWrite_ID  = rw;
    bus.MemRead_ID   = mr;
    bus.MemWrite_ID  = mw;
    bus.MD_Read_ID   = md;
  endtask

  task automatic nop();                               set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic alu(input int rd, input int rs, input int rt); set_id(rs, rt, rd, 1, 1, 1, 0, 0, 0); endtask
  task automatic lw(input int rt, input int base);   set_id(base, rt, rt, 1, 0, 1, 1, 0, 0); endtask
  task automatic sw(input int rt, input int base);   set_id(base, rt, 0, 1, 1, 0, 0, 1, 0); endtask
  task automatic step();                             @(posedge clk); #1; endtask
  task automatic drain();                            nop(); repeat (3) step(); endtask

  int stall_cnt;

  initial begin
    bus.Branch_Taken_EX = 1'b0;
    bus.MD_Busy         = 1'b0;
    nop();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    #1;
    check("rst_fwdA",  32'(bus.Forward_A_EX), 32'd0);
    check("rst_fwdB",  32'(bus.Forward_B_EX), 32'd0);
    check("rst_stall", 32'(bus.Stall_IF_ID),  32'd0);
    check("rst_state", 32'(dut.state_q),      32'(ST_RUN));

    // add $3 then sub uses $3 immediately: producer in MEM
    alu(3, 1, 2);  step();
    alu(7, 3, 8);  step();
    nop(); #1;
    check("adj_fwdA", 32'(bus.Forward_A_EX), 32'h1);
    check("adj_fwdB", 32'(bus.Forward_B_EX), 32'h0);
    step();

    // two apart: producer in WB
    alu(12, 1, 2); step();
    nop();         step();
    alu(13, 12, 0); step();
    nop(); #1;
    check("gap2_fwdA", 32'(bus.Forward_A_EX), 32'h2);
    check("gap2_fwdB", 32'(bus.Forward_B_EX), 32'h0);
    step();

    // $0 destination is never forwarded
    alu(0, 1, 2);  step();
    alu(14, 0, 0); step();
    nop(); #1;
    check("r0_fwdA", 32'(bus.Forward_A_EX), 32'h0);
    check("r0_fwdB", 32'(bus.Forward_B_EX), 32'h0);
    step();

    // both MEM and WB write $15: MEM wins
    alu(15, 1, 2);   step();
    alu(15, 3, 4);   step();
    alu(16, 15, 15); step();
    nop(); #1;
    check("prio_fwdA", 32'(bus.Forward_A_EX), 32'h1);
    check("prio_fwdB", 32'(bus.Forward_B_EX), 32'h1);

    // lw $4 ; add $5,$4,$4 -> one stall cycle then WB forwarding
    drain();
    lw(4, 29);    step();
    alu(5, 4, 4); #1;
    check("lu_stall",  32'(bus.Stall_IF_ID),  32'd1);
    check("lu_bubble", 32'(bus.Bubble_ID_EX), 32'd1);
    check("lu_flush",  32'(bus.Flush_IF_ID),  32'd0);
    step(); #1;
    check("lu_stall2", 32'(bus.Stall_IF_ID),  32'd0);
    check("lu_state",  32'(dut.state_q),      32'(ST_LOAD_STALL));
    step();
    nop(); #1;
    check("lu_fwdA", 32'(bus.Forward_A_EX), 32'h2);
    check("lu_fwdB", 32'(bus.Forward_B_EX), 32'h2);

    // lw $4 ; sw $4,0($6) -> no stall, store data forwarded in MEM
    drain();
    lw(4, 29); step();
    sw(4, 6);  #1;
    check("st_stall",  32'(bus.Stall_IF_ID),  32'd0);
    check("st_bubble", 32'(bus.Bubble_ID_EX), 32'd0);
    step();
    nop(); #1;
    check("st_fwdmem0", 32'(bus.Forward_MEM),  32'd0);
    check("st_fwdB",    32'(bus.Forward_B_EX), 32'h1);
    step(); #1;
    check("st_fwdmem1", 32'(bus.Forward_MEM),  32'd1);

    // mult issue then mflo with the MD unit busy for 5 cycles
    drain();
    set_id(8, 9, 0, 1, 1, 0, 0, 0, 1); #1;
    check("md_issue_stall", 32'(bus.Stall_IF_ID), 32'd0);
    step();
    set_id(0, 0, 10, 0, 0, 1, 0, 0, 1);
    bus.MD_Busy = 1'b1;
    stall_cnt   = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (bus.Stall_IF_ID) stall_cnt++;
      step();
    end
    bus.MD_Busy = 1'b0; #1;
    check("md_stall_cycles", 32'(stall_cnt),       32'd5);
    check("md_release",      32'(bus.Stall_IF_ID), 32'd0);
    check("md_state_wait",   32'(dut.state_q),     32'(ST_MD_WAIT));
    step(); #1;
    check("md_state_run",    32'(dut.state_q),     32'(ST_RUN));

    // load-use hazard coinciding with a taken branch: flush wins
    drain();
    lw(4, 29);    step();
    alu(5, 4, 0); bus.Branch_Taken_EX = 1'b1; #1;
    check("br_flush",  32'(bus.Flush_IF_ID),  32'd1);
    check("br_stall",  32'(bus.Stall_IF_ID),  32'd0);
    check("br_bubble", 32'(bus.Bubble_ID_EX), 32'd1);
    step();
    bus.Branch_Taken_EX = 1'b0; nop(); #1;
    check("br_state", 32'(dut.state_q), 32'(ST_RUN));

    // reset during MD_WAIT with a producer in flight and a branch pending
    drain();
    alu(11, 1, 2); step();
    set_id(0, 0, 10, 0, 0, 1, 0, 0, 1); bus.MD_Busy = 1'b1; step();
    #1;
    check("rs_state_wait", 32'(dut.state_q), 32'(ST_MD_WAIT));
    alu(17, 11, 11);
    bus.Branch_Taken_EX = 1'b1;
    reset = 1'b1; #1;
    check("rs_stall",  32'(bus.Stall_IF_ID),  32'd0);
    check("rs_bubble", 32'(bus.Bubble_ID_EX), 32'd0);
    check("rs_flush",  32'(bus.Flush_IF_ID),  32'd0);
    step();
    reset = 1'b0; bus.Branch_Taken_EX = 1'b0; bus.MD_Busy = 1'b0; nop(); #1;
    check("rs_state_run", 32'(dut.state_q),      32'(ST_RUN));
    check("rs_no_stale",  32'(bus.Forward_A_EX), 32'h0);
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
